// File: rtl/miv_axi4_pkg.sv
// miv_axi4_pkg: AXI4 burst/response encodings and the slave FSM state type
// shared by the SRAM slave.
// Optional feature macro: MIV_AXI4_SRAM_WRAP_EN (enables WRAP burst support).
package miv_axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_FETCH,
    RD_DATA
  } state_t;

  // A burst is serviceable if it is FIXED/INCR, or WRAP with a legal length.
  function automatic logic burst_ok(input logic [1:0] burst, input logic wrap_len_ok);
    logic ok;
    ok = 1'b0;
    case (burst)
      BURST_FIXED, BURST_INCR: ok = 1'b1;
      BURST_WRAP:              ok = wrap_len_ok;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/miv_sram_1rw.sv
// miv_sram_1rw: single-port 64-bit SRAM with 8 byte enables and a 1-cycle
// registered read. Each byte lane is its own array so the write enables map
// straight onto block RAM byte-write columns.
module miv_sram_1rw #(
  parameter int WORD_AW = 9
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [WORD_AW-1:0] addr,
  input  logic [63:0]        wdata,
  input  logic [7:0]         be,
  output logic [63:0]        rdata
);

  localparam int WORDS = 1 << WORD_AW;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] mem [WORDS];
      logic [7:0] rd_reg;

      // Byte-lane write under its strobe; read data held until the next read.
      always_ff @(posedge clk) begin
        if (we && be[gi]) mem[addr] <= wdata[gi*8 +: 8];
        if (re) rd_reg <= mem[addr];
      end

      assign rdata[gi*8 +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/miv_axi4_sram_slave.sv
// miv_axi4_sram_slave: AXI4 slave memory serving one transaction at a time
// from an on-chip byte-enabled SRAM.
// Optional feature macro: MIV_AXI4_SRAM_WRAP_EN (WRAP bursts with len 1/3/7/15).
module miv_axi4_sram_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST
);

  import miv_axi4_pkg::*;

  state_t                state_reg;
  logic                  prio_wr_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [ADDR_WIDTH-1:0] step;
  logic [7:0]            len_reg;
  logic [7:0]            beat_reg;
  logic [2:0]            size_reg;
  logic [1:0]            burst_reg;
  logic                  err_reg;
  logic                  wlast_err_reg;
  logic                  rlast_reg;
  logic [1:0]            bresp_reg;
  logic [1:0]            rresp_reg;
  logic [ID_WIDTH-1:0]   bid_reg;
  logic [ID_WIDTH-1:0]   rid_reg;

  logic                  ar_hs;
  logic                  aw_hs;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [7:0]            acc_len;
  logic [2:0]            acc_size;
  logic [1:0]            acc_burst;
  logic                  acc_wrap_ok;
  logic [63:0]           sram_rdata;

  // Request arbitration: prio_wr picks the winner only when both are valid.
  assign ARREADY = (state_reg == IDLE) && !(AWVALID && prio_wr_reg);
  assign AWREADY = (state_reg == IDLE) && !(ARVALID && !prio_wr_reg);
  assign ar_hs   = ARVALID && ARREADY;
  assign aw_hs   = AWVALID && AWREADY;

  assign acc_addr  = ar_hs ? ARADDR  : AWADDR;
  assign acc_len   = ar_hs ? ARLEN   : AWLEN;
  assign acc_size  = ar_hs ? ARSIZE  : AWSIZE;
  assign acc_burst = ar_hs ? ARBURST : AWBURST;

  assign step = ADDR_WIDTH'(1) << size_reg;

`ifdef MIV_AXI4_SRAM_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign acc_wrap_ok = acc_len inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign wrap_mask   = ((ADDR_WIDTH'(len_reg) + ADDR_WIDTH'(1)) << size_reg) - ADDR_WIDTH'(1);

  // Next beat address: FIXED holds, WRAP stays inside its aligned window, INCR steps.
  always_comb begin
    addr_next = addr_reg + step;
    if (burst_reg == BURST_FIXED)
      addr_next = addr_reg;
    else if (burst_reg == BURST_WRAP)
      addr_next = (addr_reg & ~wrap_mask) | ((addr_reg + step) & wrap_mask);
  end
`else
  assign acc_wrap_ok = 1'b0;

  // Next beat address: FIXED holds, everything else steps (wraps at 2^ADDR_WIDTH).
  always_comb begin
    addr_next = addr_reg + step;
    if (burst_reg == BURST_FIXED)
      addr_next = addr_reg;
  end
`endif

  // Transaction FSM with registered response/ID/last outputs.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg     <= IDLE;
      prio_wr_reg   <= 1'b0;
      addr_reg      <= '0;
      len_reg       <= '0;
      beat_reg      <= '0;
      size_reg      <= '0;
      burst_reg     <= '0;
      err_reg       <= 1'b0;
      wlast_err_reg <= 1'b0;
      rlast_reg     <= 1'b0;
      bresp_reg     <= RESP_OKAY;
      rresp_reg     <= RESP_OKAY;
      bid_reg       <= '0;
      rid_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ar_hs || aw_hs) begin
            addr_reg      <= acc_addr;
            len_reg       <= acc_len;
            size_reg      <= acc_size;
            burst_reg     <= acc_burst;
            beat_reg      <= '0;
            err_reg       <= !burst_ok(acc_burst, acc_wrap_ok);
            wlast_err_reg <= 1'b0;
            prio_wr_reg   <= ~prio_wr_reg;
            if (ar_hs) begin
              rid_reg   <= ARID;
              state_reg <= RD_FETCH;
            end else begin
              bid_reg   <= AWID;
              state_reg <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (WVALID) begin
            if (beat_reg == len_reg) begin
              bresp_reg <= (err_reg || wlast_err_reg || !WLAST) ? RESP_SLVERR : RESP_OKAY;
              state_reg <= WR_RESP;
            end else begin
              if (WLAST) wlast_err_reg <= 1'b1;
              beat_reg <= beat_reg + 8'd1;
              addr_reg <= addr_next;
            end
          end
        end
        WR_RESP: begin
          if (BREADY) state_reg <= IDLE;
        end
        RD_FETCH: begin
          rresp_reg <= err_reg ? RESP_SLVERR : RESP_OKAY;
          rlast_reg <= (beat_reg == len_reg);
          state_reg <= RD_DATA;
        end
        RD_DATA: begin
          if (RREADY) begin
            rlast_reg <= 1'b0;
            if (rlast_reg) begin
              state_reg <= IDLE;
            end else begin
              beat_reg  <= beat_reg + 8'd1;
              addr_reg  <= addr_next;
              state_reg <= RD_FETCH;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  miv_sram_1rw #(
    .WORD_AW (ADDR_WIDTH - 3)
  ) u_sram (
    .clk   (CLK),
    .we    ((state_reg == WR_DATA) && WVALID && !err_reg),
    .re    (state_reg == RD_FETCH),
    .addr  (addr_reg[ADDR_WIDTH-1:3]),
    .wdata (WDATA),
    .be    (WSTRB),
    .rdata (sram_rdata)
  );

  assign WREADY = (state_reg == WR_DATA);
  assign BVALID = (state_reg == WR_RESP);
  assign RVALID = (state_reg == RD_DATA);
  assign BID    = bid_reg;
  assign BRESP  = bresp_reg;
  assign RID    = rid_reg;
  assign RRESP  = rresp_reg;
  assign RLAST  = rlast_reg;
  // SRAM output register is only reloaded in RD_FETCH, so RDATA holds during a stall.
  assign RDATA  = (RVALID && !err_reg) ? sram_rdata : '0;

endmodule

// File: tb/tb_miv_axi4_sram_slave.sv
// tb_miv_axi4_sram_slave: directed self-checking bench for miv_axi4_sram_slave.
module tb_miv_axi4_sram_slave;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [3:0]  AWID, BID, ARID, RID;
  logic [11:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [63:0] WDATA, RDATA;

  int checks = 0;
  int errors = 0;

  logic [63:0] wdata_q [16];
  logic [7:0]  wstrb_q [16];
  logic [63:0] rdata_q [16];
  logic [1:0]  rresp_q [16];
  logic        rlast_q [16];
  int          rwait_q [16];
  logic [3:0]  rid_got, bid_got;
  logic [1:0]  bresp_got;

  always #5 CLK = ~CLK;

  miv_axi4_sram_slave #(.ID_WIDTH(4), .ADDR_WIDTH(12), .DATA_WIDTH(64)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, AWREADY, 1'b1);
    check({tag, "_arready"}, ARREADY, 1'b1);
    check({tag, "_wready"},  WREADY,  1'b0);
    check({tag, "_bvalid"},  BVALID,  1'b0);
    check({tag, "_rvalid"},  RVALID,  1'b0);
    check({tag, "_rlast"},   RLAST,   1'b0);
    check({tag, "_bid"},     BID,     4'd0);
    check({tag, "_bresp"},   BRESP,   2'd0);
    check({tag, "_rid"},     RID,     4'd0);
    check({tag, "_rdata"},   RDATA,   64'd0);
    check({tag, "_rresp"},   RRESP,   2'd0);
  endtask

  // Full write: AW, len+1 W beats from wdata_q/wstrb_q, then B.
  task automatic axi_write(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int last_beat);
    int n;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd3; AWBURST = burst; AWVALID = 1'b1;
    #1;
    n = 0;
    while (!AWREADY && n < 20) begin step(); n++; end
    if (n >= 20) check("aw_timeout", 1'b1, 1'b0);
    step();
    AWVALID = 1'b0;
    check("wready_after_aw", WREADY, 1'b1);
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = wdata_q[b]; WSTRB = wstrb_q[b]; WLAST = (b == last_beat); WVALID = 1'b1;
      #1;
      n = 0;
      while (!WREADY && n < 20) begin step(); n++; end
      if (n >= 20) check("w_timeout", 1'b1, 1'b0);
      step();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check("bvalid_after_last", BVALID, 1'b1);
    BREADY = 1'b1;
    #1;
    n = 0;
    while (!BVALID && n < 20) begin step(); n++; end
    if (n >= 20) check("b_timeout", 1'b1, 1'b0);
    bid_got = BID; bresp_got = BRESP;
    step();
    BREADY = 1'b0;
    $display("WR id=%0d addr=%h len=%0d burst=%0d -> bid=%0d bresp=%0d", id, addr, len, burst, bid_got, bresp_got);
  endtask

  // Full read: AR, then len+1 R beats captured into rdata_q/rresp_q/rlast_q.
  task automatic axi_read(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
    int n;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd3; ARBURST = burst; ARVALID = 1'b1;
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin step(); n++; end
    if (n >= 20) check("ar_timeout", 1'b1, 1'b0);
    step();
    ARVALID = 1'b0;
    RREADY = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!RVALID && n < 20) begin step(); n++; end
      if (n >= 20) check("r_timeout", 1'b1, 1'b0);
      rwait_q[b] = n; rdata_q[b] = RDATA; rresp_q[b] = RRESP; rlast_q[b] = RLAST; rid_got = RID;
      step();
    end
    RREADY = 1'b0;
    $display("RD id=%0d addr=%h len=%0d burst=%0d -> rid=%0d data0=%h rresp0=%0d", id, addr, len, burst,
             rid_got, rdata_q[0], rresp_q[0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_wrap [4];
    AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
    ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; RREADY = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    RESETN = 1'b1;
    step();

    // Single write then read back.
    wdata_q[0] = 64'h1122334455667788; wstrb_q[0] = 8'hFF;
    axi_write(4'd3, 12'h010, 8'd0, 2'b01, 0);
    check("single_bresp", bresp_got, 2'b00);
    check("single_bid", bid_got, 4'd3);
    axi_read(4'd5, 12'h010, 8'd0, 2'b01);
    check("single_rdata", rdata_q[0], 64'h1122334455667788);
    check("single_rlast", rlast_q[0], 1'b1);
    check("single_rid", rid_got, 4'd5);
    check("single_rresp", rresp_q[0], 2'b00);
    check("single_latency", rwait_q[0], 1);

    // INCR burst crossing the top of memory.
    for (int i = 0; i < 4; i++) begin wdata_q[i] = 64'(i + 1); wstrb_q[i] = 8'hFF; end
    axi_write(4'd1, 12'hFF0, 8'd3, 2'b01, 3);
    check("incr_bresp", bresp_got, 2'b00);
    axi_read(4'd2, 12'hFF0, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rdata_q[i], 64'(i + 1));
      check("incr_rlast", rlast_q[i], (i == 3));
      check("incr_gap", rwait_q[i], 1);
    end
    axi_read(4'd2, 12'h000, 8'd0, 2'b01);
    check("incr_wrap_word0", rdata_q[0], 64'd3);

    // Byte strobes.
    wdata_q[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb_q[0] = 8'hFF;
    axi_write(4'd0, 12'h020, 8'd0, 2'b01, 0);
    wdata_q[0] = 64'h0; wstrb_q[0] = 8'h0F;
    axi_write(4'd0, 12'h020, 8'd0, 2'b01, 0);
    axi_read(4'd0, 12'h020, 8'd0, 2'b01);
    check("strb_rdata", rdata_q[0], 64'hFFFF_FFFF_0000_0000);

    // Unsupported burst write must not touch memory.
    wdata_q[0] = 64'h18; wstrb_q[0] = 8'hFF;
    axi_write(4'd0, 12'h018, 8'd0, 2'b01, 0);
    wdata_q[0] = 64'hDEAD;
    axi_write(4'd9, 12'h018, 8'd0, 2'b11, 0);
    check("rsvd_wr_bresp", bresp_got, 2'b10);
    check("rsvd_wr_bid", bid_got, 4'd9);
    axi_read(4'd0, 12'h018, 8'd0, 2'b01);
    check("rsvd_wr_nowrite", rdata_q[0], 64'h18);

    // Early WLAST.
    wdata_q[0] = 64'hAAAA; wdata_q[1] = 64'hBBBB; wstrb_q[0] = 8'hFF; wstrb_q[1] = 8'hFF;
    axi_write(4'd4, 12'h200, 8'd1, 2'b01, 0);
    check("early_wlast_bresp", bresp_got, 2'b10);
    axi_read(4'd0, 12'h200, 8'd0, 2'b01);
    check("early_wlast_kept", rdata_q[0], 64'hAAAA);

    // Reserved burst read.
    axi_read(4'd7, 12'h010, 8'd0, 2'b11);
    check("rsvd_rd_rdata", rdata_q[0], 64'd0);
    check("rsvd_rd_rresp", rresp_q[0], 2'b10);
    check("rsvd_rd_rlast", rlast_q[0], 1'b1);

    // WRAP read of 4 beats from 0x018.
    axi_read(4'd8, 12'h018, 8'd3, 2'b10);
`ifdef MIV_AXI4_SRAM_WRAP_EN
    exp_wrap[0] = 64'h18; exp_wrap[1] = 64'd3; exp_wrap[2] = 64'd4; exp_wrap[3] = 64'h1122334455667788;
    for (int i = 0; i < 4; i++) begin
      check("wrap_rdata", rdata_q[i], exp_wrap[i]);
      check("wrap_rresp", rresp_q[i], 2'b00);
      check("wrap_rlast", rlast_q[i], (i == 3));
    end
`else
    for (int i = 0; i < 4; i++) exp_wrap[i] = 64'd0;
    for (int i = 0; i < 4; i++) begin
      check("wrap_rdata", rdata_q[i], exp_wrap[i]);
      check("wrap_rresp", rresp_q[i], 2'b10);
      check("wrap_rlast", rlast_q[i], (i == 3));
    end
`endif

    // Arbitration after reset: read first, write second, with a 5-cycle R stall.
    RESETN = 1'b0;
    step();
    RESETN = 1'b1;
    step();
    AWID = 4'd6; AWADDR = 12'h030; AWLEN = 8'd0; AWSIZE = 3'd3; AWBURST = 2'b01; AWVALID = 1'b1;
    ARID = 4'd7; ARADDR = 12'h010; ARLEN = 8'd0; ARSIZE = 3'd3; ARBURST = 2'b01; ARVALID = 1'b1;
    #1;
    check("arb_arready", ARREADY, 1'b1);
    check("arb_awready", AWREADY, 1'b0);
    step();
    ARVALID = 1'b0;
    step();
    check("arb_rvalid", RVALID, 1'b1);
    check("arb_rdata", RDATA, 64'h1122334455667788);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_rvalid", RVALID, 1'b1);
      check("stall_rdata", RDATA, 64'h1122334455667788);
      check("stall_rlast", RLAST, 1'b1);
      check("stall_awready", AWREADY, 1'b0);
    end
    $display("RD id=7 addr=010 len=0 burst=1 -> rid=%0d data0=%h (stalled 5 cycles)", RID, RDATA);
    check("arb_rid", RID, 4'd7);
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    check("arb_wr_second", AWREADY, 1'b1);
    WDATA = 64'h3030; WSTRB = 8'hFF; WLAST = 1'b1; WVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    check("arb_wready", WREADY, 1'b1);
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    check("arb_bvalid", BVALID, 1'b1);
    check("arb_bid", BID, 4'd6);
    check("arb_bresp", BRESP, 2'b00);
    $display("WR id=6 addr=030 len=0 burst=1 -> bid=%0d bresp=%0d", BID, BRESP);
    step();
    BREADY = 1'b0;
    axi_read(4'd1, 12'h030, 8'd0, 2'b01);
    check("arb_wr_data", rdata_q[0], 64'h3030);

    // Reset during beat 2 of an 8-beat write.
    for (int i = 0; i < 8; i++) begin wdata_q[i] = 64'hA0 + 64'(i); wstrb_q[i] = 8'hFF; end
    axi_write(4'd2, 12'h100, 8'd7, 2'b01, 7);
    AWID = 4'd2; AWADDR = 12'h100; AWLEN = 8'd7; AWSIZE = 3'd3; AWBURST = 2'b01; AWVALID = 1'b1;
    #1;
    check("mid_awready", AWREADY, 1'b1);
    step();
    AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      WDATA = 64'hB0 + 64'(b); WSTRB = 8'hFF; WLAST = 1'b0; WVALID = 1'b1;
      #1;
      check("mid_wready", WREADY, 1'b1);
      step();
    end
    WDATA = 64'hB2; WVALID = 1'b1;
    #2;
    RESETN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    $display("WR id=2 addr=100 len=7 burst=1 -> aborted by reset in beat 2");
    WVALID = 1'b0;
    step();
    step();
    RESETN = 1'b1;
    step();
    axi_read(4'd3, 12'h100, 8'd7, 2'b01);
    for (int i = 0; i < 8; i++) begin
      check("midrst_mem", rdata_q[i], (i < 2) ? 64'hB0 + 64'(i) : 64'hA0 + 64'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
